// File: rtl/fetch_pkg.sv
// Shared types and defaults for the rv5stage instruction-fetch front end.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        error;
    } FetchEntry;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries; head entry is read straight from storage flops,
// so nothing on the write side reaches the outputs in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type entry_t = FetchEntry,
    parameter int  DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  entry_t                     enq_data,
    input  logic                       deq_ready,
    output logic                       head_valid,
    output entry_t                     head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic             deq_s;

    assign deq_s      = deq_ready && (count_q != CNT_W'(0));
    assign head_valid = (count_q != CNT_W'(0));
    assign head_data  = mem_q[head_q];
    assign count      = count_q;

    // Pointer, count and storage next-state; flush wins over enqueue/dequeue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            head_d  = PTR_W'(0);
            tail_d  = PTR_W'(0);
            count_d = CNT_W'(0);
        end else begin
            if (enq_valid) begin
                mem_d[tail_q] = enq_data;
                tail_d        = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (deq_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({enq_valid, deq_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= PTR_W'(0);
            tail_q  <= PTR_W'(0);
            count_q <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Decoupled fetch front end: sequential PC generation, credit-limited in-order
// icache requests, redirect flush with drop-by-count of stale responses.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEFAULT),
    parameter int              QUEUE_DEPTH     = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ic_req_valid,
    input  logic            ic_req_ready,
    output logic [XLEN-1:0] ic_req_addr,
    input  logic            ic_resp_valid,
    input  logic [31:0]     ic_resp_inst,
    input  logic            ic_resp_error,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic            out_error,
    output logic            busy
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int SUM_W = CNT_W + OUT_W;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            error;
    } entry_t;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             halted_q, halted_d;
    logic             req_hold_q, req_hold_d;

    logic [CNT_W-1:0] q_count_s;
    logic [SUM_W-1:0] credit_s;
    logic             can_issue_s;
    logic             accept_s;
    logic             resp_counted_s;
    logic             enq_s;
    logic [XLEN-1:0]  redirect_aligned_s;
    entry_t           enq_data_s;
    entry_t           head_s;

    // Issue gating. A request already presented and stalled stays up even if a
    // fault halts fetch meanwhile, so the icache never sees it vanish.
    always_comb begin
        credit_s     = SUM_W'(q_count_s) + SUM_W'(outstanding_q) - SUM_W'(drop_cnt_q);
        can_issue_s  = !halted_q
                       && (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                       && (credit_s < SUM_W'(QUEUE_DEPTH));
        ic_req_valid = !rst && !redirect_valid && (req_hold_q || can_issue_s);
        ic_req_addr  = fetch_pc_q;
    end

    assign accept_s           = ic_req_valid && ic_req_ready;
    assign resp_counted_s     = ic_resp_valid && (outstanding_q != OUT_W'(0));
    assign enq_s              = ic_resp_valid && !redirect_valid && (drop_cnt_q == OUT_W'(0));
    assign redirect_aligned_s = {redirect_pc[XLEN-1:2], 2'b00};
    assign enq_data_s         = '{pc: resp_pc_q, inst: ic_resp_inst, error: ic_resp_error};

    // PC, credit, drop and halt next-state.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        halted_d      = halted_q;
        outstanding_d = outstanding_q;
        req_hold_d    = ic_req_valid && !ic_req_ready;

        case ({accept_s, resp_counted_s})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned_s;
            resp_pc_d  = redirect_aligned_s;
            halted_d   = 1'b0;
            drop_cnt_d = resp_counted_s ? (outstanding_q - OUT_W'(1)) : outstanding_q;
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (ic_resp_valid && (drop_cnt_q != OUT_W'(0))) begin
                drop_cnt_d = drop_cnt_q - OUT_W'(1);
            end else if (enq_s) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                halted_d  = halted_q || ic_resp_error;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // Front-end state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= OUT_W'(0);
            drop_cnt_q    <= OUT_W'(0);
            halted_q      <= 1'b0;
            req_hold_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            halted_q      <= halted_d;
            req_hold_q    <= req_hold_d;
        end
    end

    fetch_queue #(
        .entry_t (entry_t),
        .DEPTH   (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .enq_valid  (enq_s),
        .enq_data   (enq_data_s),
        .deq_ready  (out_ready),
        .head_valid (out_valid),
        .head_data  (head_s),
        .count      (q_count_s)
    );

    assign out_pc    = head_s.pc;
    assign out_inst  = head_s.inst;
    assign out_error = head_s.error;
    assign busy      = (outstanding_q != OUT_W'(0));

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised, decoupled instruction-fetch front end for the rv5stage core. It generates sequential PCs and keeps up to MAX_OUTSTANDING in-order requests in flight to the icache. Returned instructions are buffered in a QUEUE_DEPTH-entry fetch queue that feeds decode over a valid/ready handshake. Redirects from execute/commit flush the queue and discard stale in-flight responses by count.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h80000000, first fetch address after reset
QUEUE_DEPTH, 4, fetch-queue entries (power of two, >=2)
MAX_OUTSTANDING, 2, max icache requests in flight (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
redirect_valid  input  1  redirect fetch; flushes queue
redirect_pc  input  XLEN  new PC; bits [1:0] ignored (forced 0)
ic_req_valid  output  1  request to icache
ic_req_ready  input  1  icache accepts request
ic_req_addr  output  XLEN  request address
ic_resp_valid  input  1  in-order response
ic_resp_inst  input  32  fetched instruction
ic_resp_error  input  1  access fault for that response
out_valid  output  1  queue head valid to decode
out_ready  input  1  decode accepts head
out_pc  output  XLEN  head PC
out_inst  output  32  head instruction
out_error  output  1  head carries fetch fault
busy  output  1  outstanding != 0

Behaviour:
- Reset values: ic_req_valid=0, out_valid=0, busy=0, fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, drop_cnt=0, queue empty, halted=0. The first request may be issued the cycle after rst deasserts.
- Counters:
  - outstanding is in-flight requests, width $clog2(MAX_OUTSTANDING+1).
  - +1 on request accepted (ic_req_valid && ic_req_ready); -1 on ic_resp_valid; both in the same cycle leaves it unchanged.
- Issue condition: ic_req_valid = !redirect_valid && !halted && outstanding < MAX_OUTSTANDING && (queue_count + outstanding - drop_cnt) < QUEUE_DEPTH.
  - This credit rule guarantees the queue never overflows.
  - ic_req_addr = fetch_pc. On accept, fetch_pc += 4, wrapping mod 2^XLEN.
- Request stability: ic_req_valid/addr are held stable while stalled. The only exception is a redirect, which may withdraw them; the icache treats a withdrawn request as never issued.
- Redirect, in the redirect_valid cycle:
  - no request issued;
  - next cycle fetch_pc = resp_pc = {redirect_pc[XLEN-1:2], 2'b00};
  - queue emptied (head = tail = count = 0), halted cleared;
  - drop_cnt <= outstanding minus 1 if ic_resp_valid this cycle (that response is itself discarded).
  - A redirect while drop_cnt>0 recomputes drop_cnt the same way.
  - Redirect has priority over an enqueue or dequeue in the same cycle.
- Response handling:
  - If drop_cnt>0: discard the response, drop_cnt--.
  - Otherwise enqueue {resp_pc, ic_resp_inst, ic_resp_error} and resp_pc += 4.
- Fault:
  - Enqueueing an entry with error=1 sets halted; no further requests are issued until a redirect.
  - Responses already in flight are still enqueued.
- Queue:
  - Circular buffer; pointers of width $clog2(QUEUE_DEPTH); count of width $clog2(QUEUE_DEPTH)+1.
  - out_* driven from the head register with no combinational path from ic_resp_* (minimum one-cycle response-to-decode latency).
  - Dequeue when out_valid && out_ready.
  - Simultaneous enqueue and dequeue leaves count unchanged, including when full or empty (enqueue to empty: data visible next cycle).
- Reset mid-operation: all state returns to reset values. Responses arriving after reset to requests issued before it are the icache's responsibility; the icache clears its own state on the same rst.
- busy: lets commit/fence logic wait for the front end to drain.

Decomposition:
- Package fetch_pkg: typedef FetchEntry {pc[XLEN], inst[32], error}; localparam RESET_PC_DEFAULT = 32'h80000000.
- Sub-module fetch_queue: parametrised circular FIFO of FetchEntry with synchronous flush input and count output.
- fetch_prefetch_unit contains the PC generator, credit/outstanding/drop logic and halt flag.

Test Plan:
1. Reset release, icache ready every cycle with 1-cycle response latency, out_ready=1 -> requests 0x80000000, 0x80000004, 0x80000008...; out_pc follows the same sequence with the instructions in order; outstanding never exceeds 2.
2. out_ready=0, QUEUE_DEPTH=4 -> exactly 4 requests total are issued and the queue fills to count=4 with no overflow. Raise out_ready -> the 4 entries drain in order and fetch resumes at 0x80000010.
3. Two requests in flight (0x80000000, 0x80000004), then redirect_pc=0x80000102 -> both late responses discarded (drop_cnt 2->0); next request addr 0x80000100; first out_pc = 0x80000100.
4. Response arrives in the redirect cycle with outstanding=2 -> drop_cnt=1 and exactly one further response is discarded; the queue is empty the cycle after the redirect.
5. ic_resp_error=1 on 0x80000008 -> entry delivered with out_error=1 and the pc; no new requests while halted; redirect to 0x80000200 clears halt and fetch restarts there.
6. rst asserted mid-stream with the queue holding 3 entries -> next cycle out_valid=0, ic_req_valid=0; after release the first request is 0x80000000.
